frame_raster_unloader: RTL and testbench

Output-side counterpart of the separable FIR pipeline. It captures the column-major pixel stream from the vertical FIR stage into a full-frame buffer, then reads it back in raster order (row by row) over a ready/valid stream with frame and line markers. It sits between the FIR pipeline output (pixel_out/valid_out) and the image sink (DMA, display or testbench file writer).

---
 rtl/frame_raster_unloader_pkg.sv | 31 +++
 rtl/frame_buffer_ram.sv | 31 +++
 rtl/frame_raster_unloader.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_raster_unloader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_raster_unloader_pkg.sv
// Shared definitions for the separable FIR pipeline and its raster unloader:
// state encoding, default frame geometry and derived widths.
package frame_raster_unloader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } marker_t;

   // Width of a counter or address that must hold values 0..n-1; never zero.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_IMAGE_WIDTH  = 110;
   localparam int DEF_IMAGE_HEIGHT = 103;
   localparam int IMAGE_SIZE       = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
   localparam int FRAME_ADDR_WIDTH = clog2_min1(IMAGE_SIZE);
   localparam int FRAME_COL_WIDTH  = clog2_min1(DEF_IMAGE_WIDTH);
   localparam int FRAME_ROW_WIDTH  = clog2_min1(DEF_IMAGE_HEIGHT);

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port
// with a single cycle of read latency.
module frame_buffer_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/frame_raster_unloader.sv
// Captures a column-major pixel stream into a frame buffer, then replays it
// in raster order over a ready/valid stream with sof/eol/eof markers.
module frame_raster_unloader
   import frame_raster_unloader_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eol,
   output logic                  m_eof,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overflow
);

   localparam int SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int AW   = clog2_min1(SIZE);
   localparam int CW   = clog2_min1(IMAGE_WIDTH);
   localparam int RW   = clog2_min1(IMAGE_HEIGHT);

   localparam logic [AW-1:0] ADDR_STRIDE = AW'(IMAGE_WIDTH);
   localparam logic [CW-1:0] COL_LAST    = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST    = RW'(IMAGE_HEIGHT - 1);

   state_t state_reg, state_next;
   logic   start_accept;
   logic   wr_en, wr_last;
   logic   rd_issue, push, pop, final_pop;

   logic [RW-1:0] wr_row_reg;
   logic [CW-1:0] wr_col_reg;
   logic [AW-1:0] waddr_reg;

   logic [RW-1:0] rd_row_reg;
   logic [CW-1:0] rd_col_reg;
   logic [AW-1:0] raddr_reg;
   logic          rd_done_reg;
   logic          rd_pending_reg;
   marker_t       rd_marker_reg;
   marker_t       issue_marker;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic [DATA_WIDTH-1:0] fifo_data_reg   [FIFO_DEPTH];
   marker_t               fifo_marker_reg [FIFO_DEPTH];
   logic                  fifo_wptr_reg, fifo_rptr_reg;
   logic [1:0]            fifo_count_reg;
   logic [2:0]            fifo_room_used;
   marker_t               head_marker;

   logic overflow_reg;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      start_accept = 1'b0;
      busy         = (state_reg != ST_IDLE);
      frame_done   = final_pop;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next   = ST_FILL;
               start_accept = 1'b1;
            end
         end
         ST_FILL: begin
            if (wr_last) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (final_pop) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------ capture side
   assign wr_en   = (state_reg == ST_FILL) && valid_in;
   assign wr_last = wr_en && (wr_row_reg == ROW_LAST) && (wr_col_reg == COL_LAST);

   // Column-major input lands at row*W+col; stepping by W avoids a multiplier.
   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         wr_row_reg <= '0;
         wr_col_reg <= '0;
         waddr_reg  <= '0;
      end else if (wr_en) begin
         if (wr_row_reg == ROW_LAST) begin
            wr_row_reg <= '0;
            wr_col_reg <= wr_col_reg + CW'(1);
            waddr_reg  <= AW'(wr_col_reg) + AW'(1);
         end else begin
            wr_row_reg <= wr_row_reg + RW'(1);
            waddr_reg  <= waddr_reg + ADDR_STRIDE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         overflow_reg <= 1'b0;
      end else if ((state_reg == ST_DRAIN) && valid_in) begin
         overflow_reg <= 1'b1;
      end
   end

   frame_buffer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SIZE),
      .ADDR_WIDTH (AW)
   ) u_frame_buffer_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (waddr_reg),
      .wr_data (pixel_in),
      .rd_en   (rd_issue),
      .rd_addr (raddr_reg),
      .rd_data (ram_rdata)
   );

   // ------------------------------------------------------------- drain side
   assign push = rd_pending_reg;
   assign pop  = (fifo_count_reg != 2'd0) && m_ready;

   // Counting this cycle's pop lets a read issue every cycle under full flow
   // while never letting stored + in-flight data exceed the two skid slots.
   assign fifo_room_used = {1'b0, fifo_count_reg} + {2'b00, rd_pending_reg} - {2'b00, pop};
   assign rd_issue = (state_reg == ST_DRAIN) && !rd_done_reg && (fifo_room_used < 3'd2);

   assign issue_marker.sof = (rd_row_reg == '0) && (rd_col_reg == '0);
   assign issue_marker.eol = (rd_col_reg == COL_LAST);
   assign issue_marker.eof = (rd_row_reg == ROW_LAST) && (rd_col_reg == COL_LAST);

   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         rd_row_reg  <= '0;
         rd_col_reg  <= '0;
         raddr_reg   <= '0;
         rd_done_reg <= 1'b0;
      end else if (rd_issue) begin
         raddr_reg <= raddr_reg + AW'(1);
         if (rd_col_reg == COL_LAST) begin
            rd_col_reg <= '0;
            rd_row_reg <= rd_row_reg + RW'(1);
         end else begin
            rd_col_reg <= rd_col_reg + CW'(1);
         end
         if (issue_marker.eof) begin
            rd_done_reg <= 1'b1;
         end
      end
   end

   // Markers travel alongside the read so they arrive with the RAM data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pending_reg <= 1'b0;
         rd_marker_reg  <= '0;
      end else begin
         rd_pending_reg <= rd_issue;
         rd_marker_reg  <= issue_marker;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         fifo_wptr_reg  <= 1'b0;
         fifo_rptr_reg  <= 1'b0;
         fifo_count_reg <= 2'd0;
      end else begin
         if (push) begin
            fifo_wptr_reg <= ~fifo_wptr_reg;
         end
         if (pop) begin
            fifo_rptr_reg <= ~fifo_rptr_reg;
         end
         fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
         always_ff @(posedge clk) begin
            if (reset) begin
               fifo_data_reg[gi]   <= '0;
               fifo_marker_reg[gi] <= '0;
            end else if (push && (int'(fifo_wptr_reg) == gi)) begin
               fifo_data_reg[gi]   <= ram_rdata;
               fifo_marker_reg[gi] <= rd_marker_reg;
            end
         end
      end
   endgenerate

   assign head_marker = fifo_marker_reg[fifo_rptr_reg];
   assign final_pop   = pop && head_marker.eof;

   assign m_valid  = (fifo_count_reg != 2'd0);
   assign m_data   = fifo_data_reg[fifo_rptr_reg];
   assign m_sof    = m_valid && head_marker.sof;
   assign m_eol    = m_valid && head_marker.eol;
   assign m_eof    = m_valid && head_marker.eof;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_frame_raster_unloader.sv
// Directed and randomized checks of the raster unloader on a 4x3 frame and
// on the default 110x103 frame, against a column-major -> raster model.
module tb_frame_raster_unloader;

   localparam int SW = 4;
   localparam int SH = 3;
   localparam int SN = SW * SH;
   localparam int BW = 110;
   localparam int BH = 103;
   localparam int BN = BW * BH;

   logic clk = 1'b0;
   logic reset;

   logic       s_start, s_vin, s_ready;
   logic [7:0] s_pixel, s_data;
   logic       s_valid, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf;

   logic       b_start, b_vin, b_ready;
   logic [7:0] b_pixel, b_data;
   logic       b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_ovf;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] fin [SN];

   always #5 clk = ~clk;

   frame_raster_unloader #(.DATA_WIDTH(8), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .pixel_in(s_pixel), .valid_in(s_vin),
      .m_data(s_data), .m_valid(s_valid), .m_ready(s_ready), .m_sof(s_sof), .m_eol(s_eol),
      .m_eof(s_eof), .busy(s_busy), .frame_done(s_done), .overflow(s_ovf)
   );

   frame_raster_unloader u_big (
      .clk(clk), .reset(reset), .start(b_start), .pixel_in(b_pixel), .valid_in(b_vin),
      .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready), .m_sof(b_sof), .m_eol(b_eol),
      .m_eof(b_eof), .busy(b_busy), .frame_done(b_done), .overflow(b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start pulse, then SN pixels on consecutive cycles; optionally one extra
   // pixel (99) in the first DRAIN cycle.
   task automatic feed_small(input bit inject);
      @(negedge clk);
      s_start = 1'b1;
      for (int k = 0; k < SN; k++) begin
         @(negedge clk);
         s_start = 1'b0;
         s_vin   = 1'b1;
         s_pixel = fin[k];
      end
      @(negedge clk);
      s_vin   = inject;
      s_pixel = 8'd99;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeated.
   task automatic drain_small(input int mode);
      int idx = 0;
      int r, c;
      bit stalled = 1'b0;
      logic [11:0] held = '0;
      for (int cyc = 0; cyc < 200 && idx < SN; cyc++) begin
         @(negedge clk);
         s_vin   = 1'b0;
         s_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         #1;
         if (stalled) check("stall_hold", {20'd0, s_valid, s_data, s_sof, s_eol, s_eof}, {20'd0, held});
         if (s_valid && s_ready) begin
            r = idx / SW;
            c = idx % SW;
            check("pixel", {21'd0, s_data, s_sof, s_eol, s_eof},
                  {21'd0, fin[c*SH + r], idx == 0, c == SW - 1, idx == SN - 1});
            check("frame_done", {31'd0, s_done}, {31'd0, idx == SN - 1});
            idx++;
         end else begin
            check("frame_done_idle", {31'd0, s_done}, 32'd0);
         end
         stalled = s_valid && !s_ready;
         held    = {s_valid, s_data, s_sof, s_eol, s_eof};
      end
      check("handshakes", idx, SN);
      @(negedge clk);
      #1;
      check("busy_after", {31'd0, s_busy}, 32'd0);
      check("valid_after", {31'd0, s_valid}, 32'd0);
   endtask

   initial begin
      int idx, eols, r, c;
      bit stalled;
      logic [11:0] held;

      reset = 1'b1;
      s_start = 1'b0; s_vin = 1'b0; s_ready = 1'b0; s_pixel = '0;
      b_start = 1'b0; b_vin = 1'b0; b_ready = 1'b0; b_pixel = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_small", {24'd0, s_data, s_valid, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf}, 32'd0);
      check("reset_big", {24'd0, b_data, b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_ovf}, 32'd0);

      // Ramp frame, full-rate sink
      for (int k = 0; k < SN; k++) fin[k] = 8'(k);
      feed_small(1'b0);
      drain_small(0);
      check("overflow_t1", {31'd0, s_ovf}, 32'd0);

      // Same frame, stalling sink
      feed_small(1'b0);
      drain_small(1);

      // valid_in in IDLE is ignored; random frame contents
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         s_vin   = 1'b1;
         s_pixel = 8'($urandom);
      end
      @(negedge clk);
      s_vin = 1'b0;
      #1;
      check("idle_busy", {31'd0, s_busy}, 32'd0);
      check("idle_overflow", {31'd0, s_ovf}, 32'd0);
      for (int k = 0; k < SN; k++) fin[k] = 8'($urandom);
      feed_small(1'b0);
      drain_small(0);
      check("overflow_t3", {31'd0, s_ovf}, 32'd0);

      // Extra pixel during DRAIN sets sticky overflow and is dropped
      for (int k = 0; k < SN; k++) fin[k] = 8'(k);
      feed_small(1'b1);
      drain_small(0);
      check("overflow_set", {31'd0, s_ovf}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      check("overflow_sticky", {31'd0, s_ovf}, 32'd1);

      // start clears overflow; reset mid-fill; then a clean frame
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      #1;
      check("overflow_cleared", {31'd0, s_ovf}, 32'd0);
      check("busy_fill", {31'd0, s_busy}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         s_vin   = 1'b1;
         s_pixel = 8'hA0 + 8'(k);
      end
      @(negedge clk);
      s_vin = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_busy", {31'd0, s_busy}, 32'd0);
      check("midreset_valid", {31'd0, s_valid}, 32'd0);
      for (int k = 0; k < SN; k++) fin[k] = 8'(k);
      feed_small(1'b0);
      drain_small(0);

      // Default geometry, ramp input, random sink readiness
      @(negedge clk);
      b_start = 1'b1;
      for (int k = 0; k < BN; k++) begin
         @(negedge clk);
         b_start = 1'b0;
         b_vin   = 1'b1;
         b_pixel = 8'(k);
      end
      @(negedge clk);
      b_vin = 1'b0;
      idx = 0;
      eols = 0;
      stalled = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 60000 && idx < BN; cyc++) begin
         @(negedge clk);
         b_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (stalled) check("big_stall_hold", {20'd0, b_valid, b_data, b_sof, b_eol, b_eof}, {20'd0, held});
         if (b_valid && b_ready) begin
            r = idx / BW;
            c = idx % BW;
            check("big_pixel", {20'd0, b_data, b_sof, b_eol, b_eof, b_done},
                  {20'd0, 8'((c*BH + r) % 256), idx == 0, c == BW - 1, idx == BN - 1, idx == BN - 1});
            if (b_eol) eols++;
            idx++;
         end
         stalled = b_valid && !b_ready;
         held    = {b_valid, b_data, b_sof, b_eol, b_eof};
      end
      check("big_handshakes", idx, BN);
      check("big_eol_count", eols, BH);
      @(negedge clk);
      #1;
      check("big_busy_after", {31'd0, b_busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
